// File: rtl/alu_pkg.sv
// Shared types, widths and 74181 function codes for the nibble-serial ALU.
package alu_pkg;

  localparam int unsigned NIB = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Common S3..S0 codes (arithmetic unless noted)
  localparam logic [3:0] ALU_ADD = 4'b1001;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_DEC = 4'b1111;
  localparam logic [3:0] ALU_DBL = 4'b1100;
  localparam logic [3:0] ALU_AND = 4'b1011;  // logic mode
  localparam logic [3:0] ALU_XOR = 4'b0110;  // logic mode
  localparam logic [3:0] ALU_NOT = 4'b0000;  // logic mode

  // 74181 internal propagate-like term, selected by S1..S0
  function automatic logic [NIB-1:0] fn_x(input logic [NIB-1:0] a4,
                                          input logic [NIB-1:0] b4,
                                          input logic [1:0]     s10);
    fn_x = a4 | (b4 & {NIB{s10[0]}}) | (~b4 & {NIB{s10[1]}});
  endfunction

  // 74181 internal generate-like term, selected by S3..S2
  function automatic logic [NIB-1:0] fn_y(input logic [NIB-1:0] a4,
                                          input logic [NIB-1:0] b4,
                                          input logic [1:0]     s32);
    fn_y = (a4 & b4 & {NIB{s32[1]}}) | (a4 & ~b4 & {NIB{s32[0]}});
  endfunction

endpackage

// File: rtl/alu_seq_w_slice4.sv
// Combinational 4-bit 74181-compatible slice: result nibble, carry-out and carry into bit 3.
module alu_slice4
  import alu_pkg::*;
(
  input  logic [NIB-1:0] a4,
  input  logic [NIB-1:0] b4,
  input  logic [3:0]     s,
  input  logic           m,
  input  logic           ci,
  output logic [NIB-1:0] f4,
  output logic           co,
  output logic           c3
);

  logic [NIB-1:0] x;
  logic [NIB-1:0] y;
  logic [NIB:0]   sum;

  always_comb begin
    x   = fn_x(a4, b4, s[1:0]);
    y   = fn_y(a4, b4, s[3:2]);
    sum = {1'b0, x} + {1'b0, y} + {{NIB{1'b0}}, ci};
    f4  = sum[NIB-1:0];
    co  = sum[NIB];
    // carry into the top bit recovered from its sum bit
    c3  = sum[NIB-1] ^ x[NIB-1] ^ y[NIB-1];
    if (m) begin
      f4 = ~(x ^ y);
      co = 1'b0;
      c3 = 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq_w.sv
// W-bit 74181-compatible ALU, nibble-serial with valid/ready handshakes and registered result.
// Define ALU_FAST_EN to compute the full width on the accept edge (replicated slices).
module alu_seq_w
  import alu_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [3:0]   s,
  input  logic         m,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] f,
  output logic         cout,
  output logic         ovf,
  output logic         zero,
  output logic         aeqb
);

  localparam int unsigned NS = W / NIB;

  state_t       state, state_nxt;
  logic [W-1:0] f_nxt;
  logic         cout_nxt;
  logic         ovf_nxt;

  assign in_ready = (state == IDLE) && !rst;
  assign zero     = (f == '0);
  assign aeqb     = &f;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Result and flag registers; held while waiting in DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f         <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      f         <= f_nxt;
      cout      <= cout_nxt;
      ovf       <= ovf_nxt;
      out_valid <= (state_nxt == DONE);
    end
  end

`ifdef ALU_FAST_EN

  logic [NS:0]   cc;
  logic [NS-1:0] c3v;
  logic [W-1:0]  f_full;
  logic          unused_c3;

  assign cc[0]     = cin & ~m;
  assign unused_c3 = ^c3v;

  for (genvar i = 0; i < NS; i++) begin : g_slice
    alu_slice4 u_slice (
      .a4 (a[i*NIB +: NIB]),
      .b4 (b[i*NIB +: NIB]),
      .s  (s),
      .m  (m),
      .ci (cc[i]),
      .f4 (f_full[i*NIB +: NIB]),
      .co (cc[i+1]),
      .c3 (c3v[i])
    );
  end

  always_comb begin
    state_nxt = state;
    f_nxt     = f;
    cout_nxt  = cout;
    ovf_nxt   = ovf;
    case (state)
      IDLE: begin
        if (in_valid) begin
          f_nxt     = f_full;
          cout_nxt  = cc[NS];
          ovf_nxt   = c3v[NS-1] ^ cc[NS];
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`else

  localparam int unsigned KW = (NS > 1) ? $clog2(NS) : 1;

  logic [KW-1:0]  k, k_nxt;
  logic           carry, carry_nxt;
  logic [W-1:0]   opa, opa_nxt;
  logic [W-1:0]   opb, opb_nxt;
  logic [3:0]     ops, ops_nxt;
  logic           opm, opm_nxt;
  logic [NIB-1:0] sl_f;
  logic           sl_co;
  logic           sl_c3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k     <= '0;
      carry <= 1'b0;
      opa   <= '0;
      opb   <= '0;
      ops   <= '0;
      opm   <= 1'b0;
    end else begin
      k     <= k_nxt;
      carry <= carry_nxt;
      opa   <= opa_nxt;
      opb   <= opb_nxt;
      ops   <= ops_nxt;
      opm   <= opm_nxt;
    end
  end

  alu_slice4 u_slice (
    .a4 (opa[k*NIB +: NIB]),
    .b4 (opb[k*NIB +: NIB]),
    .s  (ops),
    .m  (opm),
    .ci (carry),
    .f4 (sl_f),
    .co (sl_co),
    .c3 (sl_c3)
  );

  always_comb begin
    state_nxt = state;
    f_nxt     = f;
    cout_nxt  = cout;
    ovf_nxt   = ovf;
    k_nxt     = k;
    carry_nxt = carry;
    opa_nxt   = opa;
    opb_nxt   = opb;
    ops_nxt   = ops;
    opm_nxt   = opm;
    case (state)
      IDLE: begin
        if (in_valid) begin
          opa_nxt   = a;
          opb_nxt   = b;
          ops_nxt   = s;
          opm_nxt   = m;
          carry_nxt = cin & ~m;
          k_nxt     = '0;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        f_nxt[k*NIB +: NIB] = sl_f;
        carry_nxt           = sl_co;
        k_nxt               = k + KW'(1);
        // last slice: its carries become the result flags
        if (k == KW'(NS - 1)) begin
          cout_nxt  = sl_co;
          ovf_nxt   = sl_c3 ^ sl_co;
          k_nxt     = '0;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`endif

endmodule

// File: tb/tb_alu_seq_w.sv
// Directed-vector bench for alu_seq_w at W=8 (table) and W=16 (carry chain, mid-op reset).
module tb_alu_seq_w;
  import alu_pkg::*;

`ifdef ALU_FAST_EN
  localparam int LAT8  = 0;
  localparam int LAT16 = 0;
`else
  localparam int LAT8  = 2;
  localparam int LAT16 = 4;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst8, iv8, ir8, m8, cin8, ov8, ordy8, cout8, ovf8, zero8, aeqb8;
  logic [7:0]  a8, b8, f8;
  logic [3:0]  s8;
  logic        rst16, iv16, ir16, m16, cin16, ov16, ordy16, cout16, ovf16, zero16, aeqb16;
  logic [15:0] a16, b16, f16;
  logic [3:0]  s16;

  int n_checks = 0;
  int n_errors = 0;

  alu_seq_w #(.W(8)) u8 (
    .clk(clk), .rst(rst8), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .s(s8),
    .m(m8), .cin(cin8), .out_valid(ov8), .out_ready(ordy8), .f(f8), .cout(cout8),
    .ovf(ovf8), .zero(zero8), .aeqb(aeqb8)
  );

  alu_seq_w #(.W(16)) u16 (
    .clk(clk), .rst(rst16), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16), .s(s16),
    .m(m16), .cin(cin16), .out_valid(ov16), .out_ready(ordy16), .f(f16), .cout(cout16),
    .ovf(ovf16), .zero(zero16), .aeqb(aeqb16)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] s;
    logic       m;
    logic       cin;
    logic [7:0] f;
    logic       cout;
    logic       ovf;
    logic       zero;
    logic       aeqb;
  } vec_t;

  localparam int NV = 13;
  vec_t vt [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Present one op, check the accept, scramble inputs, then wait (bounded) for out_valid
  task automatic run_op(input bit wide, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] s, input logic m, input logic cin);
    int lat;
    if (wide) begin
      a16 = a; b16 = b; s16 = s; m16 = m; cin16 = cin; iv16 = 1'b1;
      chk("in_ready16_before_accept", 32'(ir16), 32'd1);
    end else begin
      a8 = a[7:0]; b8 = b[7:0]; s8 = s; m8 = m; cin8 = cin; iv8 = 1'b1;
      chk("in_ready8_before_accept", 32'(ir8), 32'd1);
    end
    @(posedge clk); #1;
    if (wide) begin
      iv16 = 1'b0; a16 = ~a16; b16 = ~b16; s16 = ~s16; m16 = ~m16; cin16 = ~cin16;
    end else begin
      iv8 = 1'b0; a8 = ~a8; b8 = ~b8; s8 = ~s8; m8 = ~m8; cin8 = ~cin8;
    end
    lat = 0;
    while (!(wide ? ov16 : ov8) && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk(wide ? "latency16" : "latency8", 32'(lat), wide ? 32'(LAT16) : 32'(LAT8));
  endtask

  task automatic finish_op(input bit wide);
    if (wide) ordy16 = 1'b1; else ordy8 = 1'b1;
    @(posedge clk); #1;
    ordy16 = 1'b0;
    ordy8  = 1'b0;
    chk("out_valid_after_handshake", 32'(wide ? ov16 : ov8), 32'd0);
    chk("in_ready_after_handshake", 32'(wide ? ir16 : ir8), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{8'h7F, 8'h01, ALU_ADD, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[1]  = '{8'h05, 8'h05, ALU_SUB, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[2]  = '{8'hF0, 8'hFF, ALU_XOR, 1'b1, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[3]  = '{8'hF0, 8'hFF, ALU_XOR, 1'b1, 1'b1, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[4]  = '{8'h05, 8'h3C, ALU_DEC, 1'b0, 1'b0, 8'h04, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[5]  = '{8'h81, 8'h55, ALU_DBL, 1'b0, 1'b0, 8'h02, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[6]  = '{8'hC3, 8'h5A, ALU_AND, 1'b1, 1'b0, 8'h42, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[7]  = '{8'h03, 8'h05, ALU_SUB, 1'b0, 1'b0, 8'hFD, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[8]  = '{8'h80, 8'h01, ALU_SUB, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[9]  = '{8'h3C, 8'h99, ALU_NOT, 1'b1, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[10] = '{8'hFF, 8'h00, ALU_ADD, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[11] = '{8'h5A, 8'h5A, ALU_XOR, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[12] = '{8'h33, 8'h33, ALU_SUB, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1};

    rst8 = 1'b1; rst16 = 1'b1;
    iv8 = 1'b0; a8 = '0; b8 = '0; s8 = '0; m8 = 1'b0; cin8 = 1'b0; ordy8 = 1'b0;
    iv16 = 1'b0; a16 = '0; b16 = '0; s16 = '0; m16 = 1'b0; cin16 = 1'b0; ordy16 = 1'b0;

    // Reset state
    #2;
    chk("rst_in_ready8", 32'(ir8), 32'd0);
    chk("rst_out_valid8", 32'(ov8), 32'd0);
    chk("rst_f8", 32'(f8), 32'd0);
    chk("rst_cout_ovf8", 32'({cout8, ovf8}), 32'd0);
    chk("rst_zero8", 32'(zero8), 32'd1);
    chk("rst_aeqb8", 32'(aeqb8), 32'd0);
    chk("rst_in_ready16", 32'(ir16), 32'd0);
    #10;
    rst8 = 1'b0; rst16 = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready8", 32'(ir8), 32'd1);
    chk("post_rst_out_valid8", 32'(ov8), 32'd0);

    // Table-driven W=8 vectors
    for (int i = 0; i < NV; i++) begin
      run_op(1'b0, {8'h00, vt[i].a}, {8'h00, vt[i].b}, vt[i].s, vt[i].m, vt[i].cin);
      chk($sformatf("v%0d_f", i), 32'(f8), 32'(vt[i].f));
      chk($sformatf("v%0d_cout", i), 32'(cout8), 32'(vt[i].cout));
      chk($sformatf("v%0d_ovf", i), 32'(ovf8), 32'(vt[i].ovf));
      chk($sformatf("v%0d_zero", i), 32'(zero8), 32'(vt[i].zero));
      chk($sformatf("v%0d_aeqb", i), 32'(aeqb8), 32'(vt[i].aeqb));
      finish_op(1'b0);
    end

    // Backpressure: result held in DONE while new requests are ignored
    run_op(1'b0, 16'h007F, 16'h0001, ALU_ADD, 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      iv8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); s8 = 4'($urandom);
      @(posedge clk); #1;
      chk("bp_f", 32'(f8), 32'h80);
      chk("bp_flags", 32'({cout8, ovf8, zero8, aeqb8}), 32'b0100);
      chk("bp_in_ready", 32'(ir8), 32'd0);
      chk("bp_out_valid", 32'(ov8), 32'd1);
    end
    iv8 = 1'b0;
    finish_op(1'b0);
    run_op(1'b0, 16'h0012, 16'h0034, ALU_ADD, 1'b0, 1'b0);
    chk("bp_next_f", 32'(f8), 32'h46);
    chk("bp_next_cout", 32'(cout8), 32'd0);
    finish_op(1'b0);

    // W=16: carry crossing slice boundaries, then all-ones decrement
    run_op(1'b1, 16'h00FF, 16'h0001, ALU_ADD, 1'b0, 1'b0);
    chk("w16_add_f", 32'(f16), 32'h0100);
    chk("w16_add_cout_ovf", 32'({cout16, ovf16}), 32'd0);
    finish_op(1'b1);
    run_op(1'b1, 16'h0000, 16'h1234, ALU_DEC, 1'b0, 1'b0);
    chk("w16_dec_f", 32'(f16), 32'hFFFF);
    chk("w16_dec_aeqb", 32'(aeqb16), 32'd1);
    chk("w16_dec_cout", 32'(cout16), 32'd0);
    chk("w16_dec_zero", 32'(zero16), 32'd0);
    finish_op(1'b1);

    // W=16: asynchronous reset during the second BUSY cycle
    a16 = 16'hAAAA; b16 = 16'h5555; s16 = ALU_ADD; m16 = 1'b0; cin16 = 1'b0; iv16 = 1'b1;
    @(posedge clk); #1;
    iv16 = 1'b0;
    @(posedge clk); #1;
    rst16 = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(ov16), 32'd0);
    chk("midrst_f", 32'(f16), 32'd0);
    chk("midrst_in_ready", 32'(ir16), 32'd0);
    chk("midrst_zero", 32'(zero16), 32'd1);
    #2;
    rst16 = 1'b0;
    @(posedge clk); #1;
    chk("midrst_idle_ready", 32'(ir16), 32'd1);
    chk("midrst_idle_valid", 32'(ov16), 32'd0);
    run_op(1'b1, 16'h1234, 16'h1111, ALU_ADD, 1'b0, 1'b0);
    chk("after_rst_f", 32'(f16), 32'h2345);
    chk("after_rst_cout", 32'(cout16), 32'd0);
    finish_op(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
